// File: rtl/uart_pkg.sv
// UART receiver shared definitions.
// FSM state encoding, parity sense constants and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both stages reset to 1 so an idle line never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  // shift the raw line through two stages
  always_comb begin
    ff_d = {ff_q[0], d};
  end

  // synchronizer stages, idle-high on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, optional parity, one stop bit.
// Mid-bit sampling driven by a 16-bit per-bit cycle counter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        pen_q, pen_d;
  logic        ptype_q, ptype_d;
  logic        perr_q, perr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;

  // next-state and output computation for the receive FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
            pen_d   = parity_en;
            ptype_d = parity_type;
            perr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST) begin
            state_d = pen_q ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          perr_d  = rx_s != ((^shift_q) ^ ptype_q);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d      = '0;
          data_d     = shift_q;
          valid_d    = 1'b1;
          perr_out_d = perr_q & pen_q;
          ferr_d     = ~rx_s;
          state_d    = rx_s ? IDLE : BREAK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pen_q      <= pen_d;
      ptype_q    <= ptype_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
